// File: rtl/uds_ctrl.sv
// uds_ctrl: sequences tile jobs through the UDS engine under downstream credit flow control.
// Define UDS_CTRL_TIMEOUT_EN to add a DRAIN watchdog that raises a sticky err and forces completion.
module uds_ctrl #(
    parameter int LAT     = 3,
    parameter int CREDITS = 4,
    parameter int TW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_mode,
    input  logic [1:0]    cmd_scale,
    input  logic [TW-1:0] cmd_tiles,
    input  logic          src_valid,
    output logic          src_pop,
    output logic          uds_active,
    output logic          uds_idata_valid,
    output logic [1:0]    uds_function_mode,
    output logic [1:0]    uds_scale_factor,
    input  logic          uds_odata_valid,
    input  logic          sink_free,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    scale_q, scale_d;
    logic [TW-1:0] tiles_q, tiles_d;
    logic [TW-1:0] issued_q, issued_d;
    logic [TW-1:0] received_q, received_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          accept;
    logic          issue_fire;
    logic          result_seen;
    logic          wd_expired;

    assign accept      = (state_q == S_IDLE) && cmd_valid;
    assign issue_fire  = (state_q == S_ISSUE) && src_valid && (credit_q != '0) && (issued_q < tiles_q);
    assign result_seen = uds_odata_valid && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

`ifdef UDS_CTRL_TIMEOUT_EN
    localparam int WD_LIMIT = 4 * LAT + 16;
    localparam int WDW      = $clog2(WD_LIMIT + 1);

    logic [WDW-1:0] wdog_q, wdog_d;
    logic           err_q, err_d;

    // The watchdog only counts silent DRAIN cycles; any result or leaving DRAIN restarts it.
    assign wd_expired = (state_q == S_DRAIN) && !result_seen && (wdog_q == WDW'(WD_LIMIT - 1));

    always_comb begin
        wdog_d = '0;
        if ((state_q == S_DRAIN) && !result_seen) begin
            wdog_d = wdog_q + WDW'(1);
        end
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (wd_expired) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= '0;
            scale_q    <= '0;
            tiles_q    <= '0;
            issued_q   <= '0;
            received_q <= '0;
            credit_q   <= CREDIT_MAX;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            scale_q    <= scale_d;
            tiles_q    <= tiles_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            credit_q   <= credit_d;
        end
    end

    // A simultaneous issue and credit return cancel out; returns beyond CREDITS are dropped.
    always_comb begin
        credit_d = credit_q;
        if (issue_fire && !sink_free) begin
            credit_d = credit_q - CW'(1);
        end else if (!issue_fire && sink_free && (credit_q != CREDIT_MAX)) begin
            credit_d = credit_q + CW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        scale_d    = scale_q;
        tiles_d    = tiles_q;
        issued_d   = issued_q + (issue_fire ? TW'(1) : TW'(0));
        received_d = received_q + (result_seen ? TW'(1) : TW'(0));
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mode_d     = cmd_mode;
                    scale_d    = cmd_scale;
                    tiles_d    = cmd_tiles;
                    issued_d   = '0;
                    received_d = '0;
                    state_d    = (cmd_tiles == '0) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: state_d = S_ISSUE;
            S_ISSUE: begin
                if (issued_q == tiles_q) begin
                    state_d = S_DRAIN;
                end
            end
            // Using the updated count lets done follow the final result by a single cycle.
            S_DRAIN: begin
                if ((received_d == tiles_q) || wd_expired) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        uds_active = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_SETUP, S_ISSUE, S_DRAIN: uds_active = 1'b1;
            S_DONE:  done = 1'b1;
            default: busy = 1'b1;
        endcase
        src_pop           = issue_fire;
        uds_idata_valid   = issue_fire;
        uds_function_mode = mode_q;
        uds_scale_factor  = scale_q;
    end

endmodule

// File: tb/tb_uds_ctrl.sv
// Testbench for uds_ctrl: randomized jobs against a cycle-level behavioural model, with
// completed jobs scored against an expected-job queue filled when commands are issued.
module tb_uds_ctrl;
    localparam int LAT     = 3;
    localparam int CREDITS = 4;
    localparam int TW      = 8;
    localparam int DRAIN_TAIL = (LAT + 1 > 3) ? LAT + 1 : 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_mode;
    logic [1:0]    cmd_scale;
    logic [TW-1:0] cmd_tiles;
    logic          src_valid;
    logic          src_pop;
    logic          uds_active;
    logic          uds_idata_valid;
    logic [1:0]    uds_function_mode;
    logic [1:0]    uds_scale_factor;
    logic          uds_odata_valid;
    logic          sink_free;
    logic          busy;
    logic          done;
    logic          err;

    uds_ctrl #(.LAT(LAT), .CREDITS(CREDITS), .TW(TW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_mode          (cmd_mode),
        .cmd_scale         (cmd_scale),
        .cmd_tiles         (cmd_tiles),
        .src_valid         (src_valid),
        .src_pop           (src_pop),
        .uds_active        (uds_active),
        .uds_idata_valid   (uds_idata_valid),
        .uds_function_mode (uds_function_mode),
        .uds_scale_factor  (uds_scale_factor),
        .uds_odata_valid   (uds_odata_valid),
        .sink_free         (sink_free),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tiles;
        logic [1:0] mode;
        logic [1:0] scale;
    } job_t;

    job_t  expQ[$];
    job_t  headJob;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    sinkAuto = 1'b1;
    bit    srcRandom = 1'b0;
    int    manualReq = 0;
    int    manualDone = 0;
    int    pending = 0;
    logic [15:0] hist = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // UDS engine with fixed latency, downstream sink returning credits, and the tile source.
    initial begin
        uds_odata_valid = 1'b0;
        sink_free       = 1'b0;
        src_valid       = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                hist    = '0;
                pending = 0;
            end else begin
                hist = {hist[14:0], uds_idata_valid};
            end
            #1;
            uds_odata_valid = hist[LAT-1];
            if (uds_odata_valid && sinkAuto) pending++;
            if (manualReq > manualDone) begin
                sink_free = 1'b1;
                manualDone++;
            end else if (pending > 0 && $urandom_range(0, 2) != 0) begin
                sink_free = 1'b1;
                pending--;
            end else begin
                sink_free = 1'b0;
            end
            src_valid = srcRandom ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Behavioural model: issue window opens two cycles after acceptance, each issue needs a credit,
    // and done lands DRAIN_TAIL cycles after the final issue (or the cycle after an empty job).
    bit  mIdle = 1'b1;
    int  mAcc = 0;
    int  mTiles = 0;
    int  mIssued = 0;
    int  mDoneCyc = -1;
    int  mCredit = CREDITS;
    int  jobPops = 0;
    bit  expPop, expDone, expActive, acc;
    logic [1:0] lastMode = '0;
    logic [1:0] lastScale = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("reset_outputs",
                    32'({cmd_ready, busy, done, err, src_pop, uds_idata_valid, uds_active,
                         uds_function_mode, uds_scale_factor}), 32'h400);
                mIdle     = 1'b1;
                mCredit   = CREDITS;
                mDoneCyc  = -1;
                lastMode  = '0;
                lastScale = '0;
                expQ.delete();
            end else begin
                acc       = mIdle && cmd_valid;
                expPop    = !mIdle && (cyc >= mAcc + 2) && src_valid && (mCredit > 0) && (mIssued < mTiles);
                expDone   = !mIdle && (cyc == mDoneCyc);
                expActive = !mIdle && (cyc >= mAcc + 1) && !expDone;
                checkOutput("cmd_ready", 32'(cmd_ready), 32'(mIdle));
                checkOutput("busy", 32'(busy), 32'(!mIdle));
                checkOutput("src_pop", 32'(src_pop), 32'(expPop));
                checkOutput("uds_idata_valid", 32'(uds_idata_valid), 32'(expPop));
                checkOutput("uds_active", 32'(uds_active), 32'(expActive));
                checkOutput("done", 32'(done), 32'(expDone));
                checkOutput("mode_scale", 32'({uds_function_mode, uds_scale_factor}), 32'({lastMode, lastScale}));
                checkOutput("err", 32'(err), 32'd0);
                if (src_pop) jobPops++;
                if (expPop && !sink_free) mCredit--;
                else if (!expPop && sink_free && mCredit < CREDITS) mCredit++;
                if (expPop) begin
                    mIssued++;
                    if (mIssued == mTiles) mDoneCyc = cyc + DRAIN_TAIL;
                end
                if (expDone) begin
                    if (expQ.size() != 0) begin
                        headJob = expQ.pop_front();
                        checkOutput("job_tiles_issued", 32'(jobPops), 32'(headJob.tiles));
                        checkOutput("job_mode_scale", 32'({uds_function_mode, uds_scale_factor}),
                                    32'({headJob.mode, headJob.scale}));
                    end
                    mIdle = 1'b1;
                end
                if (acc) begin
                    mIdle     = 1'b0;
                    mAcc      = cyc;
                    mTiles    = int'(cmd_tiles);
                    mIssued   = 0;
                    jobPops   = 0;
                    lastMode  = cmd_mode;
                    lastScale = cmd_scale;
                    mDoneCyc  = (cmd_tiles == '0) ? cyc + 1 : -1;
                end
            end
        end
    end

    task automatic waitIdle();
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
        end
        checkOutput("wait_cmd_ready", 32'(ok), 32'd1);
    endtask

    task automatic applyStimulus(input int tiles, input logic [1:0] mode, input logic [1:0] scale);
        waitIdle();
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_tiles = TW'(tiles);
        cmd_mode  = mode;
        cmd_scale = scale;
        expQ.push_back('{tiles, mode, scale});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_tiles = TW'($urandom);
        cmd_mode  = 2'($urandom);
        cmd_scale = 2'($urandom);
    endtask

    task automatic returnCredits(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            manualReq++;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode  = '0;
        cmd_scale = '0;
        cmd_tiles = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(4, 2'b10, 2'b01);
        applyStimulus(0, 2'b11, 2'b11);

        // Credits withheld: an extra return at full credit must saturate, so only four issues fit.
        sinkAuto = 1'b0;
        returnCredits(1);
        applyStimulus(6, 2'b01, 2'b10);
        repeat (12) @(negedge clk);
        returnCredits(1);
        repeat (5) @(negedge clk);
        returnCredits(1);
        waitIdle();
        returnCredits(4);
        sinkAuto = 1'b1;

        // Reset in the middle of issuing, after two tiles went out.
        applyStimulus(8, 2'b11, 2'b00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        sinkAuto = 1'b0;
        applyStimulus(5, 2'b00, 2'b11);
        repeat (8) @(negedge clk);
        returnCredits(1);
        waitIdle();
        returnCredits(5);
        sinkAuto = 1'b1;

        srcRandom = 1'b1;
        for (int j = 0; j < 40; j++) begin
            applyStimulus($urandom_range(0, 12), 2'($urandom), 2'($urandom));
        end
        waitIdle();
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "[TB] aborted");
    end

endmodule

// File: doc/uds_ctrl.md
UDS_CTRL -- requirements
Module: uds_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 3, meaning fixed UDS latency in cycles from uds_idata_valid to the matching uds_odata_valid.
REQ-002 SHALL have parameter CREDITS, default 4, meaning number of downstream output-buffer slots.
REQ-003 SHALL have parameter TW, default 8, meaning tile-count width.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1): command handshake.
REQ-007 SHALL have ports cmd_mode (input, 2) and cmd_scale (input, 2): function_mode and scale_factor for the job.
REQ-008 SHALL have port cmd_tiles, input, TW bits: tiles in the job.
REQ-009 SHALL have ports src_valid (input, 1) and src_pop (output, 1): source tile available / consume tile.
REQ-010 SHALL have ports uds_active, uds_idata_valid (outputs, 1 each) and uds_function_mode, uds_scale_factor (outputs, 2 each): UDS control.
REQ-011 SHALL have port uds_odata_valid, input, 1 bit: UDS result strobe.
REQ-012 SHALL have port sink_free, input, 1 bit: one-cycle pulse returning one downstream credit.
REQ-013 SHALL have outputs busy, done and err, 1 bit each: job in progress / one-cycle job-complete pulse / sticky timeout.

Function
REQ-014 SHALL implement FSM IDLE, SETUP, ISSUE, DRAIN, DONE.
REQ-015 IDLE: cmd_ready=1 and busy=0; on cmd_valid, latch mode/scale/tiles and clear issued/received counters; go to DONE if tiles==0, else SETUP.
REQ-016 SETUP: drive latched mode/scale onto uds_function_mode/uds_scale_factor; set uds_active=1; go to ISSUE after exactly 1 cycle.
REQ-017 ISSUE: when src_valid && credit>0 && issued<tiles, assert src_pop=uds_idata_valid=1 combinationally in the same cycle; increment issued; decrement credit.
REQ-018 SHALL go from ISSUE to DRAIN in the cycle after issued reaches tiles.
REQ-019 received SHALL increment on each uds_odata_valid in ISSUE or DRAIN; uds_odata_valid in other states is ignored; each issued tile yields exactly one result.
REQ-020 DRAIN: go to DONE when received==tiles.
REQ-021 DONE: done=1 for one cycle; uds_active=0; return to IDLE.
REQ-022 uds_function_mode and uds_scale_factor SHALL hold constant from SETUP through DONE and SHALL not change in IDLE.
REQ-023 credit SHALL be a counter of width clog2(CREDITS+1): issue and sink_free in the same cycle leave it unchanged; sink_free at credit==CREDITS is ignored (saturate); credit persists across jobs.
REQ-024 busy SHALL be 1 in every state except IDLE; cmd_ready SHALL be 0 whenever busy=1.

Reset
REQ-025 On rst_n low, at any point including mid-job: state=IDLE; issued=received=0; credit=CREDITS; all outputs 0 except cmd_ready=1.
REQ-026 No uds_idata_valid or src_pop SHALL be asserted in the first cycle after reset release.

Configuration
REQ-027 With UDS_CTRL_TIMEOUT_EN defined: a DRAIN watchdog counts cycles without uds_odata_valid and resets on each strobe; at 4*LAT+16 cycles it sets err and forces DONE; err clears when the next command is accepted.
REQ-028 Without UDS_CTRL_TIMEOUT_EN: err is tied to 0 and DRAIN waits indefinitely.

Verification
REQ-029 cmd_tiles=4, mode=2'b10, src_valid=1, sink_free echoing results -> four consecutive uds_idata_valid pulses, four results, done 1 cycle after the fourth result.
REQ-030 cmd_tiles=6, sink_free never pulsed -> exactly 4 issues, then stall in ISSUE; each later sink_free pulse releases exactly one issue.
REQ-031 cmd_tiles=0 -> DONE the cycle after acceptance; zero src_pop; done=1 for 1 cycle.
REQ-032 Issue and sink_free in the same cycle at credit=2 -> credit remains 2; sink_free at credit=4 -> credit remains 4.
REQ-033 rst_n pulsed low mid-ISSUE with issued=2 -> IDLE, credit=4, cmd_ready=1, uds_active=0.
REQ-034 With UDS_CTRL_TIMEOUT_EN and LAT=3: withhold the last result -> err=1 and done after 28 idle DRAIN cycles; err clears on the next cmd accept.
